// File: rtl/cpa_seq_adder_pkg.sv
// cpa_seq_adder_pkg: shared widths and FSM state type for the sequential carry-propagate adder
package cpa_seq_adder_pkg;
    localparam int PROD_W = 32;
    localparam int ROW_W  = 31;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/cpa_seq_adder_chunk_add.sv
// cpa_chunk_add: combinational W-bit ripple adder built from full_adder cells
//   a, b : W-bit addends
//   cin  : carry in
//   sum  : W-bit sum
//   cout : carry out of the top bit
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (c & (a ^ b));
endmodule

module cpa_chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    assign cout = c[W];
    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .c(c[i]), .s(sum[i]), .co(c[i+1]));
    end
endmodule

// File: rtl/cpa_seq_adder.sv
// cpa_seq_adder: adds the two final Dadda rows CHUNK_W bits per cycle, LSB slice first
//   clk, rst        : clock, synchronous active-high reset
//   row0, row1      : 31-bit sum/carry rows, accepted when in_valid & in_ready
//   product         : registered 32-bit sum, valid while out_valid
//   out_ready       : consumer takes product this cycle
//   acc_clr         : only with CPA_SEQ_ACC_EN; clears the accumulator at an output transfer
// Optional macro CPA_SEQ_ACC_EN adds a 32-bit accumulator folded into every sum.
module cpa_seq_adder
    import cpa_seq_adder_pkg::*;
#(
    parameter int CHUNK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROW_W-1:0]  row0,
    input  logic [ROW_W-1:0]  row1,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready
`ifdef CPA_SEQ_ACC_EN
    ,input logic              acc_clr
`endif
);
    localparam int NCH = PROD_W / CHUNK_W;
    localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
`ifdef CPA_SEQ_ACC_EN
    localparam int CW  = 2;
`else
    localparam int CW  = 1;
`endif

    if (PROD_W % CHUNK_W != 0) begin : g_bad_chunk
        $error("CHUNK_W must divide 32");
    end

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       carry_q, carry_d;
    logic [PROD_W-1:0]   a_q, a_d, b_q, b_d, product_q, product_d, acc_q, acc_d;
    logic [4:0]          base;
    logic [CHUNK_W-1:0]  s0, sum;
    logic [CW-1:0]       cout;
    logic                xfer_in, xfer_out;

    assign base      = 5'(idx_q * CHUNK_W);
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = state_q == DONE;
    assign product   = product_q;
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = (state_q == DONE) & out_ready;

    cpa_chunk_add #(.W(CHUNK_W)) u_add0 (
        .a(a_q[base +: CHUNK_W]), .b(b_q[base +: CHUNK_W]), .cin(carry_q[0]),
        .sum(s0), .cout(cout[0])
    );

`ifdef CPA_SEQ_ACC_EN
    // The accumulator slice is folded in by a second adder; the two carries
    // each carry weight 2^CHUNK_W, so together they hold a carry of 0..2.
    cpa_chunk_add #(.W(CHUNK_W)) u_add1 (
        .a(s0), .b(acc_q[base +: CHUNK_W]), .cin(carry_q[1]),
        .sum(sum), .cout(cout[1])
    );
`else
    assign sum = s0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        product_d = product_q;
        acc_d     = acc_q;
        if (state_q == ADD) begin
            product_d[base +: CHUNK_W] = sum;
            carry_d = cout;
            idx_d   = idx_q == IW'(NCH - 1) ? '0 : idx_q + 1'b1;
            state_d = idx_q == IW'(NCH - 1) ? DONE : ADD;
        end
        if (xfer_out) begin
            state_d = IDLE;
`ifdef CPA_SEQ_ACC_EN
            acc_d = acc_clr ? '0 : product_q;
`endif
        end
        if (xfer_in) begin
            state_d = ADD;
            a_d     = PROD_W'(row0);
            b_d     = PROD_W'(row1);
            carry_d = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            acc_q     <= acc_d;
        end
    end
endmodule

// File: tb/tb_cpa_seq_adder.sv
// tb_cpa_seq_adder: directed and random checks of cpa_seq_adder against an arithmetic model
module tb_cpa_seq_adder;
    localparam int LAT = 32 / 8;

    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, acc_clr = 0;
    logic [30:0] row0 = '0, row1 = '0;
    logic        in_ready, out_valid;
    logic [31:0] product;
    logic [31:0] acc_m = '0, exp_m = '0;
    int          checks = 0, fails = 0;

    cpa_seq_adder dut (
`ifdef CPA_SEQ_ACC_EN
        .acc_clr(acc_clr),
`endif
        .clk(clk), .rst(rst), .row0(row0), .row1(row1), .in_valid(in_valid),
        .in_ready(in_ready), .product(product), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [30:0] r0, input logic [30:0] r1);
        int n = 0;
        row0 = r0;
        row1 = r1;
        in_valid = 1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_xfer", 32'(in_ready), 32'd1);
        exp_m = 32'(r0) + 32'(r1) + acc_m;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < LAT; i++) begin
            check("out_valid_busy", 32'(out_valid), 32'd0);
            check("in_ready_busy", 32'(in_ready), 32'd0);
            tick();
        end
        check("out_valid_done", 32'(out_valid), 32'd1);
        check("product", product, exp_m);
    endtask

    task automatic take(input logic clr);
        out_ready = 1;
        acc_clr = clr;
`ifdef CPA_SEQ_ACC_EN
        acc_m = clr ? 32'd0 : exp_m;
`endif
        tick();
        out_ready = 0;
        acc_clr = 0;
        check("out_valid_after_take", 32'(out_valid), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 0;
        check("rst_product", product, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

`ifdef CPA_SEQ_ACC_EN
        xfer(31'h10, 31'h20);
        wait_result();
        check("acc_first", product, 32'h30);
        take(0);
        xfer(31'h01, 31'h02);
        wait_result();
        check("acc_second", product, 32'h33);
        take(1);
        xfer(31'h05, 31'h00);
        wait_result();
        check("acc_third", product, 32'h05);
        take(1);
`endif

        xfer(31'h7FFFFFFF, 31'h00000001);
        wait_result();
`ifndef CPA_SEQ_ACC_EN
        check("ripple_all_chunks", product, 32'h80000000);
`endif
        take(1);

        xfer(31'h7FFF0000, 31'h7FFF0001);
        wait_result();
`ifndef CPA_SEQ_ACC_EN
        check("ffff_sq_rows", product, 32'hFFFE0001);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_product", product, exp_m);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        take(1);

        xfer(31'h12345678, 31'h0EDCBA98);
        for (int k = 0; k < 4; k++) begin
            wait_result();
            out_ready = 1;
`ifdef CPA_SEQ_ACC_EN
            acc_m = exp_m;
`endif
            xfer(31'($urandom), 31'($urandom));
            out_ready = 0;
        end
        wait_result();
        take(1);

        xfer(31'h7FFFFFFF, 31'h7FFFFFFF);
        tick();
        rst = 1;
        tick();
        rst = 0;
        acc_m = '0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_product", product, 32'd0);
        for (int i = 0; i < LAT + 2; i++) begin
            check("midrst_no_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        xfer(31'h3, 31'h4);
        wait_result();
        check("after_rst_sum", product, 32'h7);
        take(0);

        for (int k = 0; k < 20; k++) begin
            xfer(31'($urandom), 31'($urandom));
            wait_result();
            for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
                tick();
                check("rand_hold", product, exp_m);
            end
            take(1'($urandom));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/cpa_seq_adder.md
CPA_SEQ_ADDER -- requirements
Module: cpa_seq_adder

Interface
REQ-001 SHALL have parameter CHUNK_W, default 8, meaning bits added per cycle; legal values are 4, 8, 16 or 32.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port row0, input, 31, sum row from the final Dadda reduction stage, bit 0 = weight 2^0.
REQ-005 SHALL have port row1, input, 31, carry row from the final Dadda reduction stage, same weighting.
REQ-006 SHALL have port in_valid, input, 1, meaning row0/row1 are valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts operands this cycle.
REQ-008 SHALL have port product, output, 32, the registered final sum.
REQ-009 SHALL have port out_valid, output, 1, meaning product is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes product this cycle.

Function
REQ-011 SHALL transfer input on a cycle where in_valid and in_ready are both high, capturing row0 and row1 zero-extended to 32 bits.
REQ-012 SHALL use FSM states IDLE, ADD and DONE.
- IDLE -> ADD on input transfer.
- ADD -> DONE after the last chunk.
- DONE -> IDLE on out_ready, or DONE -> ADD on out_ready together with a new input transfer.
REQ-013 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-014 SHALL, in ADD, add one CHUNK_W slice per cycle, LSB slice first, together with a registered carry-in.
- Carry-in is 0 for slice 0.
- Each slice result is written into product.
REQ-015 SHALL make the latency from transfer edge to out_valid high exactly 32/CHUNK_W cycles (4 at default).
REQ-016 SHALL compute product = (row0 + row1) mod 2^32; the carry out of bit 31 is discarded.
REQ-017 SHALL hold out_valid high and product stable in DONE until out_ready is high.
REQ-018 SHALL keep out_valid low in IDLE and ADD.
REQ-019 SHALL ignore in_valid while in ADD; in_ready is low there.
REQ-020 SHALL, on a simultaneous output and input transfer in DONE, start the new operation with no idle cycle.

Reset
REQ-021 SHALL, while rst is high at a clock edge, set state=IDLE, product=0, out_valid=0, carry=0 and chunk index=0.
REQ-022 SHALL, on reset during ADD or DONE, discard the in-flight operation with no output produced.
REQ-023 SHALL drive in_ready high in the first cycle after reset deasserts.

Configuration
REQ-024 SHALL use macro CPA_SEQ_ACC_EN.
- When defined: add input acc_clr (1 bit) and a 32-bit accumulator.
- Each slice adds row0 + row1 + accumulator slice, using a 2-bit carry.
- The accumulator loads product on each output transfer.
- acc_clr high at an output transfer clears the accumulator to 0 instead.
- Reset clears the accumulator.
REQ-025 SHALL, when CPA_SEQ_ACC_EN is undefined, have no acc_clr port and no accumulator, and behave exactly per REQ-016.

Structure
REQ-026 SHALL place in the shared package: the FSM state enum (IDLE/ADD/DONE), localparam PROD_W=32, and localparam ROW_W=31.
REQ-027 SHALL instantiate one sub-module, cpa_chunk_add: a combinational CHUNK_W-bit adder with carry-in/out, reusing full_adder cells.
REQ-028 SHALL cause an elaboration error if 32 % CHUNK_W != 0.

Verification
REQ-029 SHALL cover: row0=0x7FFFFFFF, row1=0x00000001 -> product=0x80000000, carry rippling through all 4 chunks, out_valid 4 cycles after transfer.
REQ-030 SHALL cover: row0=0x7FFF0000, row1=0x7FFF0001 (0xFFFF*0xFFFF rows) -> product=0xFFFE0001.
REQ-031 SHALL cover: out_ready low for 3 cycles in DONE -> product/out_valid unchanged and in_ready low; transfer on the 4th cycle.
REQ-032 SHALL cover: back-to-back operands with out_ready tied high -> one result every 4 cycles with no bubble.
REQ-033 SHALL cover: rst pulsed on ADD cycle 2 -> no out_valid; the next operation 0x00000003+0x00000004 yields 0x00000007.
REQ-034 SHALL cover, with CPA_SEQ_ACC_EN: 0x10+0x20 and then 0x01+0x02 -> products 0x30 and 0x33; acc_clr on the second transfer makes the third op 0x05+0x00 give 0x05.
